lstm_sequencer: RTL and testbench
=================================

# lstm_sequencer

Drives the recurrent side of the `lstm` cell over a stream of input samples. It accepts samples from an upstream valid/ready stream and presents each one to the cell with its x-handshake. It captures `y_out`/`C_out` when the cell signals `y_valid`, and feeds them back as `h_in`/`C_in` for the next step. Each step's output is delivered on a downstream valid/ready stream, and recurrent state is cleared at sequence boundaries.

## Interface
Parameters:
- `WIDTH`, 16: signed Q8.8 data width, shared with `lstm`.
- `TIMEOUT`, 64: maximum number of cycles spent in WAIT before the step is aborted.
- `MAX_LEN`, 1024: maximum number of steps per sequence.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: reset, synchronous, active-low.
- `s_data` in WIDTH: input sample.
- `s_valid` in 1: input sample valid.
- `s_last` in 1: marks the final sample of a sequence.
- `s_ready` out 1: sequencer can accept a sample.
- `x_in` out WIDTH: sample driven to the cell.
- `x_valid` out 1: sample to the cell is valid.
- `x_ready` in 1: cell accepts the sample.
- `h_in` out WIDTH: short-term state to the cell.
- `C_in` out WIDTH: long-term state to the cell.
- `y_out` in WIDTH: cell output.
- `C_out` in WIDTH: cell long-term state output.
- `y_valid` in 1: cell result valid.
- `m_data` out WIDTH: step output, equal to the captured `y_out`.
- `m_cell` out WIDTH: captured `C_out` for the step.
- `m_valid` out 1: step output valid.
- `m_last` out 1: step output is the last of its sequence.
- `m_ready` in 1: downstream accepts the step output.
- `step_count` out clog2(MAX_LEN): index of the current step within the sequence.
- `timeout` out 1: one-cycle pulse when a step is aborted.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, EMIT.
- **IDLE:**
  - `s_ready`=1.
  - On `s_valid`, latch `s_data` into the x register and `s_last` into the last flag, then go to ISSUE.
- **ISSUE:**
  - `x_valid`=1.
  - `h_in`/`C_in` hold the h/C registers.
  - On `x_ready`, clear the watchdog and go to WAIT.
- **WAIT:**
  - The watchdog increments every cycle.
  - On `y_valid`, h←`y_out` and C←`C_out`, then go to EMIT.
  - If the watchdog reaches TIMEOUT-1 without `y_valid`, pulse `timeout`, clear h, C and `step_count`, and go to IDLE.
- **EMIT:**
  - `m_valid`=1; `m_data`=h; `m_cell`=C; `m_last`=last flag OR (`step_count`==MAX_LEN-1).
  - On `m_ready`:
    - If `m_last`, clear h, C and `step_count`.
    - Otherwise, increment `step_count`.
    - Go to IDLE.
- `y_valid` is ignored outside WAIT.
- `x_in`, `h_in` and `C_in` are stable for the whole of ISSUE and WAIT.
- No arithmetic is performed on data. Values pass through as signed Q8.8, and `step_count` never wraps.

## Timing
- Reset (`rst`=0 at a clock edge):
  - State goes to IDLE.
  - All outputs become 0, including `s_ready`. `s_ready` rises the cycle after `rst` is released.
  - h, C, `step_count` and the watchdog become 0.
- Reset asserted mid-operation in any state takes effect at the next edge. Any in-flight step is dropped with no `m_valid`.
- Latency:
  - s-handshake at cycle N gives `x_valid` at N+1.
  - `y_valid` at cycle M gives `m_valid` at M+1.
- At most one step is outstanding. `s_ready`=0 from ISSUE through EMIT.
- `x_valid` and `m_valid`, once asserted, are not withdrawn until their handshake completes. `m_data`, `m_cell` and `m_last` are held while `m_ready`=0.
- If `y_valid` arrives in the same cycle the watchdog expires, `y_valid` wins: the result is captured and no `timeout` pulse is issued.
- `timeout` is high for exactly one cycle per abort.

## Structure
- Package `lstm_pkg` holds:
  - the state enum `lstm_seq_state_t` {IDLE, ISSUE, WAIT, EMIT};
  - the constant `FRAC_BITS`=8;
  - the default `WIDTH`=16.
- No sub-module is required. The `lstm` cell is instantiated alongside this block by the parent.

## Test plan
Bench cell model: `y_out`=x+h, `C_out`=C+x, latency 3, `x_ready`=1.
- **Basic sequence:**
  - Stimulus: samples 0x0100, 0x0200, 0x0300, with `s_last` on the third.
  - Required `m_data`: 0x0100, 0x0300, 0x0600.
  - Required `m_cell`: 0x0100, 0x0300, 0x0600.
  - Required `m_last`: 0, 0, 1.
  - A following sequence starting with 0x0100 outputs 0x0100, confirming h/C were cleared.
- **Backpressure:**
  - `m_ready`=0 for 10 cycles: `m_valid`, `m_data` and `m_cell` are stable and `s_ready`=0 throughout.
  - `x_ready`=0 for 5 cycles: `x_valid` is held and `x_in` is stable.
- **Timeout:**
  - Model never asserts `y_valid`, TIMEOUT=64.
  - `timeout` pulses once, 64 cycles after entry to WAIT; `s_ready`=1 on the next cycle; h=C=0.
- **Timeout race:** `y_valid` lands on the watchdog-expiry cycle → the result is emitted and `timeout` stays 0.
- **Length cap:**
  - MAX_LEN=4, 6 samples with no `s_last`.
  - `m_last`=1 on the 4th output; the 5th output uses h=0.
- **Mid-WAIT reset:**
  - `rst`=0 for 1 cycle during WAIT: all outputs are 0 the next cycle.
  - A late `y_valid` arriving after reset is ignored; no `m_valid` is produced.

Source files
------------

// File: rtl/lstm_pkg.sv
// Shared types and constants for the lstm cell and its sequencer.
// Data is signed Q8.8; the sequencer only moves it around.
package lstm_pkg;

  localparam int FRAC_BITS  = 8;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    EMIT
  } lstm_seq_state_t;

endpackage

// File: rtl/lstm_sequencer_watchdog.sv
// Cycle counter bounding how long a step may wait for the cell result.
// Expires on the TIMEOUT-th consecutive cycle of run.
module lstm_sequencer_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count == LAST);

endmodule

// File: rtl/lstm_sequencer.sv
// Feeds samples to the lstm cell one step at a time and loops y/C back
// as h/C, emitting each step downstream and clearing state per sequence.
module lstm_sequencer
  import lstm_pkg::*;
#(
  parameter int WIDTH   = DATA_WIDTH,
  parameter int TIMEOUT = 64,
  parameter int MAX_LEN = 1024,
  localparam int SW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [WIDTH-1:0] x_in,
  output logic             x_valid,
  input  logic             x_ready,
  output logic [WIDTH-1:0] h_in,
  output logic [WIDTH-1:0] C_in,
  input  logic [WIDTH-1:0] y_out,
  input  logic [WIDTH-1:0] C_out,
  input  logic             y_valid,
  output logic [WIDTH-1:0] m_data,
  output logic [WIDTH-1:0] m_cell,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic [SW-1:0]    step_count,
  output logic             timeout
);

  localparam logic [SW-1:0] LAST_IDX = SW'(MAX_LEN - 1);

  lstm_seq_state_t state;

  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] h_q;
  logic [WIDTH-1:0] c_q;
  logic             last_q;
  logic             wd_clear;
  logic             wd_run;
  logic             wd_expired;
  logic             at_cap;

  assign x_in   = x_q;
  assign h_in   = h_q;
  assign C_in   = c_q;
  assign m_data = h_q;
  assign m_cell = c_q;

  assign wd_clear = (state == ISSUE) && x_ready;
  assign wd_run   = (state == WAIT);
  assign at_cap   = (step_count == LAST_IDX);

  lstm_sequencer_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .run     (wd_run),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      x_q        <= '0;
      h_q        <= '0;
      c_q        <= '0;
      last_q     <= 1'b0;
      step_count <= '0;
      s_ready    <= 1'b0;
      x_valid    <= 1'b0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s_ready && s_valid) begin
            x_q     <= s_data;
            last_q  <= s_last;
            s_ready <= 1'b0;
            x_valid <= 1'b1;
            state   <= ISSUE;
          end else begin
            s_ready <= 1'b1;
          end
        end
        ISSUE: begin
          if (x_ready) begin
            x_valid <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // a result on the expiry cycle still counts
          if (y_valid) begin
            h_q     <= y_out;
            c_q     <= C_out;
            m_valid <= 1'b1;
            m_last  <= last_q || at_cap;
            state   <= EMIT;
          end else if (wd_expired) begin
            timeout    <= 1'b1;
            h_q        <= '0;
            c_q        <= '0;
            step_count <= '0;
            s_ready    <= 1'b1;
            state      <= IDLE;
          end
        end
        EMIT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            s_ready <= 1'b1;
            state   <= IDLE;
            if (m_last) begin
              h_q        <= '0;
              c_q        <= '0;
              step_count <= '0;
            end else begin
              step_count <= step_count + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_sequencer.sv
// Bench for lstm_sequencer: a latency-programmable cell model plus a
// per-sequence scoreboard of expected step outputs.
module tb_lstm_sequencer;

  localparam int W  = 16;
  localparam int TO = 64;
  localparam int ML = 4;
  localparam int CW = 2;

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] c;
    logic         l;
  } step_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [W-1:0]  x_in;
  logic          x_valid;
  logic          x_ready;
  logic [W-1:0]  h_in;
  logic [W-1:0]  C_in;
  logic [W-1:0]  y_out;
  logic [W-1:0]  C_out;
  logic          y_valid;
  logic [W-1:0]  m_data;
  logic [W-1:0]  m_cell;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic [CW-1:0] step_count;
  logic          timeout;

  always #5 clk = ~clk;

  lstm_sequencer #(
    .WIDTH   (W),
    .TIMEOUT (TO),
    .MAX_LEN (ML)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .x_in       (x_in),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .h_in       (h_in),
    .C_in       (C_in),
    .y_out      (y_out),
    .C_out      (C_out),
    .y_valid    (y_valid),
    .m_data     (m_data),
    .m_cell     (m_cell),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .step_count (step_count),
    .timeout    (timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;

  step_t exp_q[$];
  step_t got_q[$];

  // reference sequence state
  logic [W-1:0] mh;
  logic [W-1:0] mc;
  int           midx;
  bit           in_wait, exp_xv, exp_mv;
  int           w_entry;

  // cell model
  bit           cell_busy, cell_mute;
  int           cell_cnt, cell_lat;
  logic [W-1:0] cx, ch, cc;

  bit rand_bp, s_fired;
  int mv_seen, to_cnt;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cycle);
    end
  endtask

  task automatic tick();
    bit sf, xf, mf, yf, rp, mv0, xv0, exp_to, exp_sr;
    logic [W-1:0] sd, xd, xh, xc, md, mcl;
    logic sl, ml;
    logic [CW-1:0] sc;
    step_t e;
    sf  = s_valid && s_ready;
    sd  = s_data;
    sl  = s_last;
    xf  = x_valid && x_ready;
    xd  = x_in;
    xh  = h_in;
    xc  = C_in;
    sc  = step_count;
    mf  = m_valid && m_ready;
    md  = m_data;
    mcl = m_cell;
    ml  = m_last;
    mv0 = m_valid && !m_ready;
    xv0 = x_valid && !x_ready;
    yf  = y_valid;
    rp  = rst;
    @(posedge clk);
    #1;
    cycle++;
    if (m_valid === 1'b1) mv_seen++;
    if (timeout === 1'b1) to_cnt++;
    s_fired = sf && rp;
    if (!rp) begin
      chk("rst_ctl", {s_ready, x_valid, m_valid, m_last, timeout,
                      step_count}, 0);
      chk("rst_data", {x_in, h_in, C_in}, 0);
      chk("rst_out", {m_data, m_cell}, 0);
      exp_q.delete();
      mh = '0; mc = '0; midx = 0;
      in_wait = 0; exp_xv = 0; exp_mv = 0;
    end else begin
      exp_to = 0;
      if (mv0) begin
        chk("m_hold_valid", m_valid, 1);
        chk("m_hold_data", {m_data, m_cell, m_last}, {md, mcl, ml});
      end
      if (xv0) begin
        chk("x_hold_valid", x_valid, 1);
        chk("x_hold_data", x_in, xd);
      end
      if (sf) begin
        e.d = sd + mh;
        e.c = mc + sd;
        e.l = sl || (midx == ML - 1);
        exp_q.push_back(e);
        exp_xv = 1;
        chk("x_latency", {x_valid, x_in}, {1'b1, sd});
      end
      if (yf && in_wait) begin
        in_wait = 0;
        exp_mv  = 1;
      end else if (in_wait && (cycle - w_entry == TO)) begin
        in_wait = 0;
        exp_to  = 1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        mh = '0; mc = '0; midx = 0;
      end
      if (xf) begin
        chk("step_idx", sc, midx);
        exp_xv  = 0;
        in_wait = 1;
        w_entry = cycle;
        if (!cell_mute) begin
          cell_busy = 1;
          cell_cnt  = cell_lat;
          cx = xd; ch = xh; cc = xc;
        end
      end
      if (mf) begin
        chk("m_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("m_data", md, e.d);
          chk("m_cell", mcl, e.c);
          chk("m_last", ml, e.l);
          got_q.push_back(e);
          got_q[got_q.size()-1].d = md;
          got_q[got_q.size()-1].c = mcl;
          got_q[got_q.size()-1].l = ml;
          if (e.l) begin
            mh = '0; mc = '0; midx = 0;
          end else begin
            mh = e.d; mc = e.c; midx++;
          end
        end
        exp_mv = 0;
      end
      if (timeout || exp_to) chk("timeout", timeout, exp_to);
      if (m_valid || exp_mv) chk("m_valid", m_valid, exp_mv);
      if (x_valid || exp_xv) chk("x_valid", x_valid, exp_xv);
      exp_sr = !(exp_xv || in_wait || exp_mv);
      if (s_ready || exp_sr) chk("s_ready", s_ready, exp_sr);
    end
    y_valid = 1'b0;
    y_out   = W'($urandom);
    C_out   = W'($urandom);
    if (cell_busy) begin
      cell_cnt--;
      if (cell_cnt <= 0) begin
        cell_busy = 0;
        y_valid   = 1'b1;
        y_out     = cx + ch;
        C_out     = cc + cx;
      end
    end
    if (rand_bp) begin
      m_ready  = ($urandom_range(0, 9) < 7);
      x_ready  = ($urandom_range(0, 9) < 7);
      cell_lat = $urandom_range(1, 6);
    end
  endtask

  task automatic send(input logic [W-1:0] d, input bit l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    do begin
      tick();
      n++;
    end while (!s_fired && n < 300);
    chk("send_wait", s_fired, 1);
    s_valid = 1'b0;
    s_data  = W'($urandom);
    s_last  = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    bit idle;
    idle = 0;
    while (!idle && n < 300) begin
      tick();
      n++;
      idle = (exp_q.size() == 0) && !exp_xv && !in_wait && !exp_mv;
    end
    chk("idle_wait", idle, 1);
  endtask

  logic [W-1:0] smp[6];
  logic [W-1:0] acc, hold_d, hold_c;
  int n;

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    x_ready = 1'b1; m_ready = 1'b1;
    y_valid = 1'b0; y_out = '0; C_out = '0;
    mh = '0; mc = '0; midx = 0;
    in_wait = 0; exp_xv = 0; exp_mv = 0; w_entry = 0;
    cell_busy = 0; cell_mute = 0; cell_cnt = 0; cell_lat = 3;
    rand_bp = 0; s_fired = 0; mv_seen = 0; to_cnt = 0;

    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("s_ready_rise", s_ready, 1);

    // basic sequence, then a fresh sequence
    got_q.delete();
    send(16'h0100, 0); wait_idle();
    send(16'h0200, 0); wait_idle();
    send(16'h0300, 1); wait_idle();
    chk("basic_n", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("basic_d0", {got_q[0].d, got_q[0].c, got_q[0].l},
          {16'h0100, 16'h0100, 1'b0});
      chk("basic_d1", {got_q[1].d, got_q[1].c, got_q[1].l},
          {16'h0300, 16'h0300, 1'b0});
      chk("basic_d2", {got_q[2].d, got_q[2].c, got_q[2].l},
          {16'h0600, 16'h0600, 1'b1});
    end
    got_q.delete();
    send(16'h0100, 1); wait_idle();
    chk("clear_n", got_q.size(), 1);
    if (got_q.size() == 1) chk("clear_d", got_q[0].d, 16'h0100);

    // downstream backpressure
    m_ready = 1'b0;
    send(16'h0040, 1);
    n = 0;
    while (!m_valid && n < 50) begin
      tick();
      n++;
    end
    chk("bp_wait", m_valid, 1);
    hold_d = m_data;
    hold_c = m_cell;
    repeat (10) tick();
    chk("bp_hold", {m_valid, s_ready, m_data, m_cell},
        {1'b1, 1'b0, hold_d, hold_c});
    m_ready = 1'b1;
    wait_idle();

    // cell backpressure
    x_ready = 1'b0;
    send(16'h0011, 1);
    repeat (5) tick();
    chk("xbp_hold", {x_valid, x_in}, {1'b1, 16'h0011});
    x_ready = 1'b1;
    wait_idle();

    // timeout clears state built up by a partial sequence
    send(16'h0050, 0); wait_idle();
    cell_mute = 1;
    to_cnt = 0;
    send(16'h0123, 0); wait_idle();
    chk("to_count", to_cnt, 1);
    tick();
    chk("to_after", {s_ready, h_in, C_in, step_count}, {1'b1, 32'h0, 2'h0});
    cell_mute = 0;
    got_q.delete();
    send(16'h0100, 1); wait_idle();
    if (got_q.size() == 1) chk("to_clear_d", got_q[0].d, 16'h0100);

    // result on the expiry cycle wins
    cell_lat = TO;
    to_cnt = 0;
    got_q.delete();
    send(16'h0007, 1); wait_idle();
    chk("race_to", to_cnt, 0);
    chk("race_n", got_q.size(), 1);

    // one cycle later is too late
    cell_lat = TO + 1;
    to_cnt = 0;
    mv_seen = 0;
    send(16'h0008, 0); wait_idle();
    repeat (3) tick();
    chk("late_to", to_cnt, 1);
    chk("late_mv", mv_seen, 0);

    // length cap
    cell_lat = 3;
    got_q.delete();
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      smp[i] = W'($urandom);
      if (i < 4) acc = acc + smp[i];
      send(smp[i], 0);
      wait_idle();
    end
    chk("cap_n", got_q.size(), 6);
    if (got_q.size() == 6) begin
      chk("cap_last3", {got_q[2].l, got_q[3].l}, 2'b01);
      chk("cap_sum", {got_q[3].d, got_q[3].c}, {acc, acc});
      chk("cap_fresh", got_q[4].d, smp[4]);
    end

    // reset while waiting for the cell
    send(16'h0099, 1);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_mv", m_valid, 0);
    rst = 1'b1;
    mv_seen = 0;
    repeat (6) tick();
    chk("mid_rst_late", mv_seen, 0);

    // random traffic
    rand_bp = 1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(W'($urandom), ($urandom_range(0, 3) == 0));
    end
    rand_bp = 0;
    m_ready = 1'b1;
    x_ready = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
